// File: rtl/bus_dma_arbiter.sv
// bus_dma_arbiter: two-master (CPU bus / DMA) arbiter for the shared memory port.
// Round-robin on ties, one owner at a time, release on done, abandon or watchdog
// timeout, followed by a fixed idle turnaround. All outputs are registered.
// Optional macro ARB_SVA_EN builds concurrent protocol assertions and covers.
module bus_dma_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned TURN_CYCLES    = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic bus_req,
  input  logic dma_req,
  input  logic done,
  output logic bus_ack,
  output logic dma_ack,
  output logic bus_enb,
  output logic mem_enb,
  output logic timeout_err
);

  localparam int unsigned CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int unsigned TW = (TURN_CYCLES > 1) ? $clog2(TURN_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] TURN_LAST = TW'(TURN_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, XFER, TURN} state_t;
  typedef enum logic {OWN_BUS, OWN_DMA} owner_t;

  state_t        state, state_nx;
  owner_t        last_owner, last_owner_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [TW-1:0] tcnt, tcnt_nx;
  logic          bus_ack_nx, dma_ack_nx, timeout_nx;
  logic          grant_dma, owner_req;

  // DMA wins when it is the only requester, or on a tie when the bus owned last.
  // last_owner is updated on grant, so during XFER it names the current owner.
  assign grant_dma = dma_req && (!bus_req || (last_owner == OWN_BUS));
  assign owner_req = (last_owner == OWN_BUS) ? bus_req : dma_req;

  // Next-state and next-output logic.
  always_comb begin
    state_nx      = state;
    last_owner_nx = last_owner;
    cnt_nx        = cnt;
    tcnt_nx       = tcnt;
    bus_ack_nx    = 1'b0;
    dma_ack_nx    = 1'b0;
    timeout_nx    = 1'b0;
    case (state)
      IDLE: begin
        if (bus_req || dma_req) begin
          state_nx      = XFER;
          cnt_nx        = '0;
          last_owner_nx = grant_dma ? OWN_DMA : OWN_BUS;
          bus_ack_nx    = !grant_dma;
          dma_ack_nx    = grant_dma;
        end
      end
      XFER: begin
        // done beats abandon beats watchdog, so an error only flags a true timeout.
        if (done || !owner_req || (cnt == CNT_LAST)) begin
          state_nx   = TURN;
          tcnt_nx    = '0;
          timeout_nx = !done && owner_req;
        end else begin
          cnt_nx     = cnt + 1'b1;
          bus_ack_nx = (last_owner == OWN_BUS);
          dma_ack_nx = (last_owner == OWN_DMA);
        end
      end
      TURN: begin
        if (tcnt == TURN_LAST) state_nx = IDLE;
        else                   tcnt_nx  = tcnt + 1'b1;
      end
      default: state_nx = IDLE;
    endcase
  end

  // State, counters and registered outputs; reset clears outputs without a clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      last_owner  <= OWN_BUS;
      cnt         <= '0;
      tcnt        <= '0;
      bus_ack     <= 1'b0;
      dma_ack     <= 1'b0;
      bus_enb     <= 1'b0;
      mem_enb     <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_nx;
      last_owner  <= last_owner_nx;
      cnt         <= cnt_nx;
      tcnt        <= tcnt_nx;
      bus_ack     <= bus_ack_nx;
      dma_ack     <= dma_ack_nx;
      bus_enb     <= bus_ack_nx;
      mem_enb     <= bus_ack_nx | dma_ack_nx;
      timeout_err <= timeout_nx;
    end
  end

`ifdef ARB_SVA_EN
  default clocking sva_cb @(posedge clk); endclocking

  a_ack_mutex: assert property (disable iff (rst) !(bus_ack && dma_ack));
  a_enb_ack:   assert property (disable iff (rst) bus_enb |-> bus_ack);
  a_mem_enb:   assert property (disable iff (rst) mem_enb == (bus_ack | dma_ack));
  a_grant:     assert property (disable iff (rst)
                 (state == IDLE) && (bus_req || dma_req) |=> (bus_ack || dma_ack));
  a_to_pulse:  assert property (disable iff (rst) timeout_err |=> !timeout_err);

  // A timeout pulse must follow TIMEOUT_CYCLES consecutive cycles of ownership.
  for (genvar i = 1; i <= TIMEOUT_CYCLES; i++) begin : g_to_hold
    a_to_hold: assert property (disable iff (rst)
                 timeout_err |-> $past(bus_ack | dma_ack, i));
  end

  c_tie:     cover property (disable iff (rst) (state == IDLE) && bus_req && dma_req);
  c_abandon: cover property (disable iff (rst) (state == XFER) && !done && !owner_req);
  c_timeout: cover property (disable iff (rst) timeout_err);
`endif

endmodule

// File: tb/tb_bus_dma_arbiter.sv
// Directed testbench for bus_dma_arbiter with hand-computed expected values.
module tb_bus_dma_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic bus_req = 1'b0;
  logic dma_req = 1'b0;
  logic done = 1'b0;
  logic bus_ack, dma_ack, bus_enb, mem_enb, timeout_err;

  int checks = 0;
  int errors = 0;

  bus_dma_arbiter #(.TIMEOUT_CYCLES(16), .TURN_CYCLES(1)) dut (
    .clk(clk), .rst(rst), .bus_req(bus_req), .dma_req(dma_req), .done(done),
    .bus_ack(bus_ack), .dma_ack(dma_ack), .bus_enb(bus_enb), .mem_enb(mem_enb),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic b_ack, input logic d_ack,
                         input logic b_enb, input logic m_enb, input logic t_err);
    chk({tag, ".bus_ack"}, bus_ack, b_ack);
    chk({tag, ".dma_ack"}, dma_ack, d_ack);
    chk({tag, ".bus_enb"}, bus_enb, b_enb);
    chk({tag, ".mem_enb"}, mem_enb, m_enb);
    chk({tag, ".timeout_err"}, timeout_err, t_err);
  endtask

  task automatic do_reset();
    bus_req = 1'b0;
    dma_req = 1'b0;
    done    = 1'b0;
    rst     = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    // 1: reset with random requests holds everything low
    for (int i = 0; i < 4; i++) begin
      bus_req = 1'($urandom_range(0, 1));
      dma_req = 1'($urandom_range(0, 1));
      done    = 1'($urandom_range(0, 1));
      tick();
      chk_out("rst_hold", 0, 0, 0, 0, 0);
    end
    bus_req = 1'b0; dma_req = 1'b0; done = 1'b0;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_out("idle_noreq", 0, 0, 0, 0, 0);
    end

    // 2: single bus request, done sampled at the third edge after grant edge
    bus_req = 1'b1;
    tick();
    chk_out("bus_c1", 1, 0, 1, 1, 0);
    tick();
    chk_out("bus_c2", 1, 0, 1, 1, 0);
    tick();
    chk_out("bus_c3", 1, 0, 1, 1, 0);
    done = 1'b1; bus_req = 1'b0;
    tick();
    chk_out("bus_c4_turn", 0, 0, 0, 0, 0);
    done = 1'b0;
    tick();
    chk_out("bus_c5_idle", 0, 0, 0, 0, 0);
    tick();
    chk_out("bus_c6_idle", 0, 0, 0, 0, 0);

    // 3: continuous tie after reset alternates DMA, BUS, DMA, BUS
    do_reset();
    bus_req = 1'b1; dma_req = 1'b1;
    tick();
    chk_out("tie_g1_dma", 0, 1, 0, 1, 0);
    tick();
    chk_out("tie_g1_hold", 0, 1, 0, 1, 0);
    for (int g = 0; g < 3; g++) begin
      done = 1'b1;
      tick();
      done = 1'b0;
      chk_out("tie_turn", 0, 0, 0, 0, 0);
      tick();
      chk_out("tie_idle", 0, 0, 0, 0, 0);
      tick();
      if (g % 2 == 0) chk_out("tie_grant_bus", 1, 0, 1, 1, 0);
      else            chk_out("tie_grant_dma", 0, 1, 0, 1, 0);
    end
    done = 1'b1;
    bus_req = 1'b0; dma_req = 1'b0;
    tick();
    done = 1'b0;
    chk_out("tie_end", 0, 0, 0, 0, 0);

    // 4: watchdog timeout after 16 ack cycles, then regrant and done on 16th cycle
    do_reset();
    dma_req = 1'b1;
    tick();
    chk_out("to_c1", 0, 1, 0, 1, 0);
    for (int c = 2; c <= 16; c++) begin
      tick();
      chk_out("to_hold", 0, 1, 0, 1, 0);
    end
    tick();
    chk_out("to_pulse", 0, 0, 0, 0, 1);
    tick();
    chk_out("to_pulse_end", 0, 0, 0, 0, 0);
    tick();
    chk_out("to_regrant", 0, 1, 0, 1, 0);
    for (int c = 2; c <= 16; c++) begin
      tick();
      chk_out("done16_hold", 0, 1, 0, 1, 0);
    end
    done = 1'b1;
    tick();
    done = 1'b0; dma_req = 1'b0;
    chk_out("done16_noerr", 0, 0, 0, 0, 0);
    tick();
    chk_out("done16_turn", 0, 0, 0, 0, 0);

    // 5: bus owner abandons in its second XFER cycle while DMA waits
    do_reset();
    bus_req = 1'b1;
    tick();
    chk_out("ab_c1", 1, 0, 1, 1, 0);
    dma_req = 1'b1;
    tick();
    chk_out("ab_c2_nopreempt", 1, 0, 1, 1, 0);
    bus_req = 1'b0;
    tick();
    chk_out("ab_drop", 0, 0, 0, 0, 0);
    tick();
    chk_out("ab_idle", 0, 0, 0, 0, 0);
    tick();
    chk_out("ab_dma_grant", 0, 1, 0, 1, 0);
    dma_req = 1'b0;
    tick();
    chk_out("ab_dma_drop", 0, 0, 0, 0, 0);

    // 6: asynchronous reset mid-XFER; last_owner returns to BUS so DMA wins the tie
    do_reset();
    dma_req = 1'b1;
    tick();
    chk_out("ar_grant", 0, 1, 0, 1, 0);
    #2;
    rst = 1'b1;
    #1;
    chk_out("ar_async", 0, 0, 0, 0, 0);
    bus_req = 1'b1;
    tick();
    chk_out("ar_held", 0, 0, 0, 0, 0);
    rst = 1'b0;
    tick();
    chk_out("ar_tie_dma", 0, 1, 0, 1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
